// File: rtl/lsu_unit.sv
// lsu_unit: single-outstanding load/store unit between decode/EXU and a valid/ready memory bus.
// Stores are lane-shifted with byte strobes. Loads come back aligned and sign/zero-extended.
// TIMEOUT bounds the REQ+RESP wait; 0 disables it.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses fault without
// reaching the bus.
module lsu_unit #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic            in_wen_i,
    input  logic [2:0]      in_func3_i,
    input  logic [XLEN-1:0] in_addr_i,
    input  logic [XLEN-1:0] in_wdata_i,
    output logic            mem_req_valid_o,
    input  logic            mem_req_ready_i,
    output logic [XLEN-1:0] mem_req_addr_o,
    output logic            mem_req_wen_o,
    output logic [XLEN-1:0] mem_req_wdata_o,
    output logic [3:0]      mem_req_wmask_o,
    input  logic            mem_resp_valid_i,
    output logic            mem_resp_ready_o,
    input  logic [XLEN-1:0] mem_resp_rdata_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_rdata_o,
    output logic            out_err_o
);

    // The counter only needs to reach TIMEOUT-1; timeout fires on the cycle that would make it TIMEOUT.
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

    state_e            state_q, state_d;
    logic              wen_q, wen_d;
    logic [2:0]        func3_q, func3_d;
    logic [1:0]        off_q, off_d;
    logic [XLEN-3:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [3:0]        wmask_q, wmask_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic [3:0]        st_mask;
    logic [XLEN-1:0]   st_wdata;
    logic [XLEN-1:0]   ld_shift, ld_ext;
    logic              timeout_hit;

    // Store lane steering from the incoming op; unknown widths behave as word stores.
    always_comb begin
        st_mask  = 4'b1111;
        st_wdata = in_wdata_i;
        case (in_func3_i)
            3'd0: begin
                st_mask  = 4'b0001 << in_addr_i[1:0];
                st_wdata = {4{in_wdata_i[7:0]}};
            end
            3'd1: begin
                st_mask  = 4'b0011 << in_addr_i[1:0];
                st_wdata = {2{in_wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic is_byte, is_half, misaligned;

    // Classify the incoming access width and flag alignment faults.
    always_comb begin
        is_byte    = (in_func3_i == 3'd0) || (!in_wen_i && (in_func3_i == 3'd4));
        is_half    = (in_func3_i == 3'd1) || (!in_wen_i && (in_func3_i == 3'd5));
        misaligned = is_half ? in_addr_i[0] : (!is_byte && (in_addr_i[1:0] != 2'b00));
    end
`endif

    // Load extraction. A half at offset 3 only has one lane left, so extend from its bit 7.
    always_comb begin
        ld_shift = mem_resp_rdata_i >> {off_q, 3'b000};
        case (func3_q)
            3'd0: ld_ext = {{(XLEN-8){ld_shift[7]}}, ld_shift[7:0]};
            3'd1: ld_ext = (off_q == 2'd3) ? {{(XLEN-8){ld_shift[7]}}, ld_shift[7:0]}
                                           : {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
            3'd4: ld_ext = {{(XLEN-8){1'b0}}, ld_shift[7:0]};
            3'd5: ld_ext = {{(XLEN-16){1'b0}}, ld_shift[15:0]};
            default: ld_ext = ld_shift;
        endcase
    end

    // Next-state logic: capture on accept, walk the bus handshakes, hold the result until taken.
    always_comb begin
        state_d     = state_q;
        wen_d       = wen_q;
        func3_d     = func3_q;
        off_d       = off_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        timeout_hit = (TIMEOUT != 0) && (cnt_q == CntLast);
        case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    wen_d   = in_wen_i;
                    func3_d = in_func3_i;
                    off_d   = in_addr_i[1:0];
                    addr_d  = in_addr_i[XLEN-1:2];
                    wdata_d = st_wdata;
                    wmask_d = st_mask;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = StReq;
`ifdef LSU_MISALIGN_TRAP_EN
                    if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end
`endif
                end
            end
            StReq: begin
                cnt_d = cnt_q + CntW'(1);
                if (timeout_hit) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = StDone;
                end else if (mem_req_ready_i) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                cnt_d = cnt_q + CntW'(1);
                // A response on the timeout cycle still counts as a good access.
                if (mem_resp_valid_i) begin
                    rdata_d = wen_q ? '0 : ld_ext;
                    err_d   = 1'b0;
                    state_d = StDone;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and capture registers; reset abandons any access in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            wen_q   <= 1'b0;
            func3_q <= '0;
            off_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wen_q   <= wen_d;
            func3_q <= func3_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake flags follow the state; data fields come straight from the capture registers.
    always_comb begin
        in_ready_o       = (state_q == StIdle);
        mem_req_valid_o  = (state_q == StReq);
        mem_resp_ready_o = (state_q == StResp);
        out_valid_o      = (state_q == StDone);
        mem_req_addr_o   = {addr_q, 2'b00};
        mem_req_wen_o    = wen_q;
        mem_req_wdata_o  = wdata_q;
        mem_req_wmask_o  = wmask_q;
        out_rdata_o      = rdata_q;
        out_err_o        = err_q;
    end

endmodule

// File: tb/tb_lsu_unit.sv
// tb_lsu_unit: directed self-checking bench for lsu_unit, built with TIMEOUT=8.
module tb_lsu_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_wen;
    logic [2:0]  in_func3;
    logic [31:0] in_addr, in_wdata;
    logic        mem_req_valid, mem_req_ready, mem_req_wen;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_resp_valid, mem_resp_ready;
    logic [31:0] mem_resp_rdata;
    logic        out_valid, out_ready, out_err;
    logic [31:0] out_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lsu_unit #(.XLEN(32), .TIMEOUT(8)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .in_wen_i        (in_wen),
        .in_func3_i      (in_func3),
        .in_addr_i       (in_addr),
        .in_wdata_i      (in_wdata),
        .mem_req_valid_o (mem_req_valid),
        .mem_req_ready_i (mem_req_ready),
        .mem_req_addr_o  (mem_req_addr),
        .mem_req_wen_o   (mem_req_wen),
        .mem_req_wdata_o (mem_req_wdata),
        .mem_req_wmask_o (mem_req_wmask),
        .mem_resp_valid_i(mem_resp_valid),
        .mem_resp_ready_o(mem_resp_ready),
        .mem_resp_rdata_i(mem_resp_rdata),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .out_rdata_o     (out_rdata),
        .out_err_o       (out_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_wen = 0; in_func3 = 0; in_addr = 0; in_wdata = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = 0; out_ready = 0;
    endtask

    // Drives one op with an always-ready bus, records the request and result (no checking).
    task automatic run_op(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rsp,
                          output logic [31:0] q_addr, output logic [31:0] q_wdata,
                          output logic [3:0] q_mask, output logic q_wen,
                          output logic [31:0] r_data, output logic r_err, output int lat);
        in_valid = 1; in_wen = wen; in_func3 = f3; in_addr = addr; in_wdata = wdata;
        mem_req_ready = 1; mem_resp_valid = 1; mem_resp_rdata = rsp; out_ready = 0;
        q_addr = 32'hx; q_wdata = 32'hx; q_mask = 4'hx; q_wen = 1'bx;
        tick();
        in_valid = 0;
        lat = 1;
        while (!out_valid && lat < 50) begin
            if (mem_req_valid) begin
                q_addr = mem_req_addr; q_wdata = mem_req_wdata;
                q_mask = mem_req_wmask; q_wen = mem_req_wen;
            end
            tick();
            lat++;
        end
        r_data = out_rdata;
        r_err  = out_err;
        out_ready = 1;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        tick(); tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b want 0", mem_req_valid); end
        checks++; if (mem_resp_ready !== 1'b0) begin errors++; $display("FAIL rst_resp_ready: got %b want 0", mem_resp_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (out_rdata !== 32'h0 || out_err !== 1'b0) begin errors++; $display("FAIL rst_out_data: got %h/%b want 0/0", out_rdata, out_err); end
        checks++; if (mem_req_addr !== 32'h0 || mem_req_wmask !== 4'h0) begin errors++; $display("FAIL rst_req_fields: got %h/%h want 0/0", mem_req_addr, mem_req_wmask); end
        rst_n = 1;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_store_word();
        logic [31:0] qa, qw, rd; logic [3:0] qm; logic qe, er; int lat;
        run_op(1'b1, 3'd2, 32'h8000_0004, 32'hDEAD_BEEF, 32'h1111_1111, qa, qw, qm, qe, rd, er, lat);
        checks++; if (qa !== 32'h8000_0004) begin errors++; $display("FAIL sw_addr: got %h want 80000004", qa); end
        checks++; if (qm !== 4'b1111) begin errors++; $display("FAIL sw_mask: got %b want 1111", qm); end
        checks++; if (qw !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_wdata: got %h want deadbeef", qw); end
        checks++; if (qe !== 1'b1) begin errors++; $display("FAIL sw_wen: got %b want 1", qe); end
        checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL sw_result: got %h/%b want 0/0", rd, er); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL sw_latency: got %0d want 3", lat); end
    endtask

    task automatic test_store_lanes();
        logic [31:0] qa, qw, rd; logic [3:0] qm; logic qe, er; int lat;
        run_op(1'b1, 3'd0, 32'h8000_0003, 32'h0000_00A5, 32'h0, qa, qw, qm, qe, rd, er, lat);
        checks++; if (qm !== 4'b1000) begin errors++; $display("FAIL sb_mask: got %b want 1000", qm); end
        checks++; if (qw !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_wdata: got %h want a5a5a5a5", qw); end
        checks++; if (qa !== 32'h8000_0000) begin errors++; $display("FAIL sb_addr: got %h want 80000000", qa); end
        run_op(1'b1, 3'd1, 32'h8000_0002, 32'h1234_BEEF, 32'h0, qa, qw, qm, qe, rd, er, lat);
        checks++; if (qm !== 4'b1100) begin errors++; $display("FAIL sh_mask: got %b want 1100", qm); end
        checks++; if (qw !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_wdata: got %h want beefbeef", qw); end
    endtask

    task automatic test_loads();
        logic [2:0]  f3s [7];
        logic [31:0] adrs[7];
        logic [31:0] rsps[7];
        logic [31:0] exps[7];
        logic [31:0] qa, qw, rd; logic [3:0] qm; logic qe, er; int lat;
        f3s[0] = 3'd0; adrs[0] = 32'h8000_0001; rsps[0] = 32'h1234_F0AB; exps[0] = 32'hFFFF_FFF0;
        f3s[1] = 3'd4; adrs[1] = 32'h8000_0001; rsps[1] = 32'h1234_F0AB; exps[1] = 32'h0000_00F0;
        f3s[2] = 3'd1; adrs[2] = 32'h8000_0002; rsps[2] = 32'h1234_F0AB; exps[2] = 32'h0000_1234;
        f3s[3] = 3'd5; adrs[3] = 32'h8000_0000; rsps[3] = 32'h0000_8001; exps[3] = 32'h0000_8001;
        f3s[4] = 3'd1; adrs[4] = 32'h8000_0000; rsps[4] = 32'h0000_8001; exps[4] = 32'hFFFF_8001;
        f3s[5] = 3'd2; adrs[5] = 32'h8000_0008; rsps[5] = 32'h89AB_CDEF; exps[5] = 32'h89AB_CDEF;
        f3s[6] = 3'd3; adrs[6] = 32'h8000_000C; rsps[6] = 32'h0000_0080; exps[6] = 32'h0000_0080;
        for (int i = 0; i < 7; i++) begin
            run_op(1'b0, f3s[i], adrs[i], 32'h0, rsps[i], qa, qw, qm, qe, rd, er, lat);
            checks++; if (rd !== exps[i] || er !== 1'b0) begin errors++; $display("FAIL load_%0d: got %h/%b want %h/0", i, rd, er, exps[i]); end
            checks++; if (qa !== {adrs[i][31:2], 2'b00} || qe !== 1'b0) begin errors++; $display("FAIL load_req_%0d: got %h/%b want %h/0", i, qa, qe, {adrs[i][31:2], 2'b00}); end
        end
    endtask

    task automatic test_misaligned();
`ifdef LSU_MISALIGN_TRAP_EN
        in_valid = 1; in_wen = 0; in_func3 = 3'd2; in_addr = 32'h8000_0002;
        mem_req_ready = 1; mem_resp_valid = 1; mem_resp_rdata = 32'h1122_3344;
        tick();
        in_valid = 0;
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL trap_no_req: got %b want 0", mem_req_valid); end
        checks++; if (out_valid !== 1'b1 || out_err !== 1'b1) begin errors++; $display("FAIL trap_out: got v=%b e=%b want 1/1", out_valid, out_err); end
        checks++; if (out_rdata !== 32'h0) begin errors++; $display("FAIL trap_rdata: got %h want 0", out_rdata); end
        out_ready = 1;
        tick();
        idle_inputs();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL trap_back_idle: got %b want 1", in_ready); end
`else
        logic [31:0] qa, qw, rd; logic [3:0] qm; logic qe, er; int lat;
        run_op(1'b0, 3'd2, 32'h8000_0002, 32'h0, 32'h1122_3344, qa, qw, qm, qe, rd, er, lat);
        checks++; if (rd !== 32'h0000_1122 || er !== 1'b0) begin errors++; $display("FAIL mis_lw: got %h/%b want 00001122/0", rd, er); end
        checks++; if (qa !== 32'h8000_0000) begin errors++; $display("FAIL mis_lw_addr: got %h want 80000000", qa); end
        run_op(1'b0, 3'd1, 32'h8000_0003, 32'h0, 32'h80FF_FFFF, qa, qw, qm, qe, rd, er, lat);
        checks++; if (rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL mis_lh3: got %h want ffffff80", rd); end
        run_op(1'b1, 3'd1, 32'h8000_0003, 32'h0000_ABCD, 32'h0, qa, qw, qm, qe, rd, er, lat);
        checks++; if (qm !== 4'b1000) begin errors++; $display("FAIL mis_sh3_mask: got %b want 1000", qm); end
`endif
    endtask

    task automatic test_backpressure();
        in_valid = 1; in_wen = 0; in_func3 = 3'd2; in_addr = 32'h8000_0010; in_wdata = 32'h0102_0304;
        tick();
        in_valid = 0; in_addr = 32'h1234_5678; in_wdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0010 || mem_req_wen !== 1'b0 ||
                mem_req_wdata !== 32'h0102_0304 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_req_hold_%0d: got v=%b a=%h w=%h rdy=%b want 1/80000010/01020304/0",
                         i, mem_req_valid, mem_req_addr, mem_req_wdata, in_ready);
            end
            tick();
        end
        mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        checks++; if (mem_req_valid !== 1'b0 || mem_resp_ready !== 1'b1) begin errors++; $display("FAIL bp_resp_state: got req=%b rr=%b want 0/1", mem_req_valid, mem_resp_ready); end
        mem_resp_valid = 1; mem_resp_rdata = 32'hCAFE_F00D;
        tick();
        mem_resp_valid = 0; mem_resp_rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_rdata !== 32'hCAFE_F00D || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_out_hold_%0d: got v=%b d=%h rdy=%b want 1/cafef00d/0", i, out_valid, out_rdata, in_ready);
            end
            tick();
        end
        out_ready = 1;
        tick();
        out_ready = 0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got rdy=%b v=%b want 1/0", in_ready, out_valid); end
        idle_inputs();
    endtask

    // Mode 0: response never comes; 1: request never accepted; 2: response on the timeout cycle.
    task automatic test_timeout();
        for (int m = 0; m < 3; m++) begin
            in_valid = 1; in_wen = 0; in_func3 = 3'd2; in_addr = 32'h8000_0020;
            mem_req_ready = (m != 1); mem_resp_valid = 0;
            tick();
            in_valid = 0;
            repeat (7) tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL to_early_%0d: got %b want 0", m, out_valid); end
            if (m == 2) begin
                mem_resp_valid = 1; mem_resp_rdata = 32'h55AA_55AA;
            end
            tick();
            mem_resp_valid = 0;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL to_fire_%0d: got %b want 1", m, out_valid); end
            checks++;
            if (m == 2) begin
                if (out_err !== 1'b0 || out_rdata !== 32'h55AA_55AA) begin errors++; $display("FAIL to_tie: got %h/%b want 55aa55aa/0", out_rdata, out_err); end
            end else begin
                if (out_err !== 1'b1 || out_rdata !== 32'h0) begin errors++; $display("FAIL to_err_%0d: got %h/%b want 0/1", m, out_rdata, out_err); end
            end
            out_ready = 1;
            tick();
            idle_inputs();
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] qa, qw, rd; logic [3:0] qm; logic qe, er; int lat;
        in_valid = 1; in_wen = 0; in_func3 = 3'd2; in_addr = 32'h8000_0040; mem_req_ready = 1;
        tick();
        in_valid = 0;
        tick();
        checks++; if (mem_resp_ready !== 1'b1) begin errors++; $display("FAIL mid_in_resp: got %b want 1", mem_resp_ready); end
        #2 rst_n = 0;
        #1;
        checks++; if (in_ready !== 1'b1 || mem_req_valid !== 1'b0 || mem_resp_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_outs: got rdy=%b req=%b rr=%b want 1/0/0", in_ready, mem_req_valid, mem_resp_ready); end
        #2 rst_n = 1;
        mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'hFFFF_FFFF;
        tick(); tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || mem_resp_ready !== 1'b0) begin errors++; $display("FAIL mid_stale_resp: got v=%b rdy=%b rr=%b want 0/1/0", out_valid, in_ready, mem_resp_ready); end
        idle_inputs();
        run_op(1'b0, 3'd4, 32'h8000_0042, 32'h0, 32'h00C3_0000, qa, qw, qm, qe, rd, er, lat);
        checks++; if (rd !== 32'h0000_00C3 || lat !== 3) begin errors++; $display("FAIL mid_recover: got %h lat %0d want 000000c3 lat 3", rd, lat); end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_store_lanes();
        test_loads();
        test_misaligned();
        test_backpressure();
        test_timeout();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
